// File: rtl/proc_run_monitor.sv
// Hardware run monitor for the single-cycle Processor: traces PC changes into a
// circular buffer, detects the halt word, drains a few cycles and then freezes.
module proc_run_monitor #(
    parameter int unsigned      DBITS        = 32,
    parameter int unsigned      TRACE_DEPTH  = 16,
    parameter logic [DBITS-1:0] HALT_WORD    = DBITS'(32'h0000DEAD),
    parameter int unsigned      DRAIN_CYCLES = 2,
    parameter int unsigned      CBITS        = 32,
    localparam int unsigned     IW           = $clog2(TRACE_DEPTH),
    localparam int unsigned     CW           = IW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DBITS-1:0] pc_in,
    input  logic [DBITS-1:0] inst_in,
    input  logic [IW-1:0]    rd_idx,
    output logic [DBITS-1:0] rd_pc,
    output logic [DBITS-1:0] rd_inst,
    output logic [CW-1:0]    trace_count,
    output logic             wrapped,
    output logic [CBITS-1:0] cycle_count,
    output logic             halted,
    output logic             running
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] inst;
    } trace_entry_t;

    trace_entry_t mem [TRACE_DEPTH];

    state_t           state, state_nxt;
    logic [IW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wrapped_nxt;
    logic [CBITS-1:0] cycle_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic [DBITS-1:0] last_pc, last_pc_nxt;
    logic             last_valid, last_valid_nxt;
    logic [DBITS-1:0] rd_pc_nxt, rd_inst_nxt;
    logic [IW-1:0]    rd_addr_c;
    logic             capture_c;

    // Next-state, counter, capture and read-port logic
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        count_nxt      = trace_count;
        wrapped_nxt    = wrapped;
        cycle_nxt      = cycle_count;
        drain_nxt      = drain_cnt;
        last_pc_nxt    = last_pc;
        last_valid_nxt = last_valid;
        capture_c      = 1'b0;
        rd_pc_nxt      = '0;
        rd_inst_nxt    = '0;

        // Index 0 is the oldest entry: once wrapped, that is the next write slot
        rd_addr_c = (wrapped ? wr_ptr : IW'(0)) + rd_idx;
        if (!clear && (CW'(rd_idx) < trace_count)) begin
            rd_pc_nxt   = mem[rd_addr_c].pc;
            rd_inst_nxt = mem[rd_addr_c].inst;
        end

        if (clear) begin
            state_nxt      = S_IDLE;
            wr_ptr_nxt     = '0;
            count_nxt      = '0;
            wrapped_nxt    = 1'b0;
            cycle_nxt      = '0;
            drain_nxt      = '0;
            last_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_RUN;
                S_RUN, S_DRAIN: begin
                    cycle_nxt = cycle_count + CBITS'(1);
                    capture_c = !last_valid || (pc_in != last_pc);
                    if (state == S_RUN) begin
                        if (inst_in == HALT_WORD) begin
                            if (DRAIN_CYCLES == 0) begin
                                state_nxt = S_HALTED;
                            end else begin
                                drain_nxt = DW'(DRAIN_CYCLES);
                                state_nxt = S_DRAIN;
                            end
                        end
                    end else begin
                        drain_nxt = drain_cnt - DW'(1);
                        if (drain_nxt == DW'(0)) state_nxt = S_HALTED;
                    end
                    if (capture_c) begin
                        wr_ptr_nxt     = wr_ptr + IW'(1);
                        last_pc_nxt    = pc_in;
                        last_valid_nxt = 1'b1;
                        if (trace_count == CW'(TRACE_DEPTH)) wrapped_nxt = 1'b1;
                        else count_nxt = trace_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            trace_count <= '0;
            wrapped     <= 1'b0;
            cycle_count <= '0;
            drain_cnt   <= '0;
            last_pc     <= '0;
            last_valid  <= 1'b0;
            rd_pc       <= '0;
            rd_inst     <= '0;
            halted      <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            trace_count <= count_nxt;
            wrapped     <= wrapped_nxt;
            cycle_count <= cycle_nxt;
            drain_cnt   <= drain_nxt;
            last_pc     <= last_pc_nxt;
            last_valid  <= last_valid_nxt;
            rd_pc       <= rd_pc_nxt;
            rd_inst     <= rd_inst_nxt;
            halted      <= (state_nxt == S_HALTED);
            running     <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
        end
    end

    // Trace RAM; capture is only possible in RUN/DRAIN, so reset blocks writes
    always_ff @(posedge clk) begin
        if (capture_c) mem[wr_ptr] <= '{pc: pc_in, inst: inst_in};
    end

endmodule

// File: tb/tb_proc_run_monitor.sv
// Directed self-checking bench for proc_run_monitor (default parameters).
module tb_proc_run_monitor;

    localparam logic [31:0] HALT = 32'h0000DEAD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] inst_in = '0;
    logic [3:0]  rd_idx = '0;
    logic [31:0] rd_pc, rd_inst;
    logic [4:0]  trace_count;
    logic        wrapped;
    logic [31:0] cycle_count;
    logic        halted, running;

    int checks = 0;
    int failures = 0;

    proc_run_monitor dut (
        .clk(clk), .reset(reset), .clear(clear), .pc_in(pc_in), .inst_in(inst_in),
        .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_inst(rd_inst), .trace_count(trace_count),
        .wrapped(wrapped), .cycle_count(cycle_count), .halted(halted), .running(running)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] nop_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic step(input logic [31:0] pc, input logic [31:0] inst);
        pc_in = pc;
        inst_in = inst;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clear = 1'b1;
        step(32'h0, nop_of(0));
        clear = 1'b0;
        step(32'h0, nop_of(0));
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (running !== 1'b0 || halted !== 1'b0) begin failures++;
            $display("FAIL reset_state running=%b halted=%b exp 0 0", running, halted); end
        checks++; if (trace_count !== 5'd0 || wrapped !== 1'b0 || cycle_count !== 32'd0) begin failures++;
            $display("FAIL reset_counters count=%0d wrapped=%b cycles=%0d exp 0 0 0", trace_count, wrapped, cycle_count); end
        checks++; if (rd_pc !== 32'd0 || rd_inst !== 32'd0) begin failures++;
            $display("FAIL reset_read rd_pc=%h rd_inst=%h exp 0 0", rd_pc, rd_inst); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12};
        step(32'h0, nop_of(0));
        checks++; if (running !== 1'b1 || trace_count !== 5'd0) begin failures++;
            $display("FAIL basic_idle running=%b count=%0d exp 1 0", running, trace_count); end
        step(0, nop_of(0)); step(4, nop_of(4)); step(8, nop_of(8)); step(8, nop_of(8)); step(12, nop_of(12));
        checks++; if (trace_count !== 5'd4) begin failures++;
            $display("FAIL basic_count got %0d exp 4", trace_count); end
        checks++; if (cycle_count !== 32'd5) begin failures++;
            $display("FAIL basic_cycles got %0d exp 5", cycle_count); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 4'(i);
            step(12, nop_of(12));
            checks++; if (rd_pc !== exp_pc[i] || rd_inst !== nop_of(exp_pc[i])) begin failures++;
                $display("FAIL basic_entry%0d pc=%h inst=%h exp %h %h", i, rd_pc, rd_inst, exp_pc[i], nop_of(exp_pc[i])); end
        end
    endtask

    task automatic test_halt();
        restart();
        step(0, nop_of(0)); step(4, nop_of(4)); step(8, nop_of(8));
        step(12, HALT);
        checks++; if (running !== 1'b1 || halted !== 1'b0) begin failures++;
            $display("FAIL halt_edge1 running=%b halted=%b exp 1 0", running, halted); end
        step(16, nop_of(16));
        checks++; if (running !== 1'b1 || halted !== 1'b0) begin failures++;
            $display("FAIL halt_edge2 running=%b halted=%b exp 1 0", running, halted); end
        step(20, nop_of(20));
        checks++; if (running !== 1'b0 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_edge3 running=%b halted=%b exp 0 1", running, halted); end
        step(24, nop_of(24));
        step(28, HALT);
        checks++; if (trace_count !== 5'd6 || cycle_count !== 32'd6 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_frozen count=%0d cycles=%0d halted=%b exp 6 6 1", trace_count, cycle_count, halted); end
        rd_idx = 4'd5;
        step(32, nop_of(32));
        checks++; if (rd_pc !== 32'd20 || rd_inst !== nop_of(20)) begin failures++;
            $display("FAIL halt_last pc=%h inst=%h exp 14 %h", rd_pc, rd_inst, nop_of(20)); end
    endtask

    task automatic test_read_port();
        rd_idx = 4'd3;
        step(36, nop_of(36));
        checks++; if (rd_pc !== 32'd12 || rd_inst !== HALT) begin failures++;
            $display("FAIL read_idx3 pc=%h inst=%h exp c %h", rd_pc, rd_inst, HALT); end
        rd_idx = 4'd6;
        step(36, nop_of(36));
        checks++; if (rd_pc !== 32'd0 || rd_inst !== 32'd0) begin failures++;
            $display("FAIL read_idx6_invalid pc=%h inst=%h exp 0 0", rd_pc, rd_inst); end
        rd_idx = 4'd10;
        step(36, nop_of(36));
        checks++; if (rd_pc !== 32'd0 || rd_inst !== 32'd0) begin failures++;
            $display("FAIL read_idx10_invalid pc=%h inst=%h exp 0 0", rd_pc, rd_inst); end
    endtask

    task automatic test_wrap();
        restart();
        for (int i = 0; i < 20; i++) step(32'(4 * i), nop_of(32'(4 * i)));
        checks++; if (wrapped !== 1'b1 || trace_count !== 5'd16) begin failures++;
            $display("FAIL wrap_state wrapped=%b count=%0d exp 1 16", wrapped, trace_count); end
        rd_idx = 4'd0;
        step(76, nop_of(76));
        checks++; if (rd_pc !== 32'd16) begin failures++;
            $display("FAIL wrap_oldest pc=%0d exp 16", rd_pc); end
        rd_idx = 4'd15;
        step(76, nop_of(76));
        checks++; if (rd_pc !== 32'd76 || rd_inst !== nop_of(76)) begin failures++;
            $display("FAIL wrap_newest pc=%0d inst=%h exp 76 %h", rd_pc, rd_inst, nop_of(76)); end
        rd_idx = 4'd0;
        step(80, nop_of(80));
        checks++; if (rd_pc !== 32'd16) begin failures++;
            $display("FAIL wrap_same_slot pc=%0d exp 16 (old contents)", rd_pc); end
        step(80, nop_of(80));
        checks++; if (rd_pc !== 32'd20 || cycle_count !== 32'd24) begin failures++;
            $display("FAIL wrap_advance pc=%0d cycles=%0d exp 20 24", rd_pc, cycle_count); end
    endtask

    task automatic test_reset_drain();
        restart();
        rd_idx = 4'd0;
        step(100, nop_of(100)); step(104, nop_of(104)); step(108, HALT); step(112, nop_of(112));
        checks++; if (running !== 1'b1 || rd_pc !== 32'd100) begin failures++;
            $display("FAIL drain_pre running=%b rd_pc=%0d exp 1 100", running, rd_pc); end
        reset = 1'b0;
        #2;
        checks++; if (running !== 1'b0 || halted !== 1'b0 || trace_count !== 5'd0 || cycle_count !== 32'd0
                      || rd_pc !== 32'd0 || rd_inst !== 32'd0 || wrapped !== 1'b0) begin failures++;
            $display("FAIL drain_async_reset running=%b halted=%b count=%0d cycles=%0d rd_pc=%h exp all 0",
                     running, halted, trace_count, cycle_count, rd_pc); end
        step(116, nop_of(116));
        checks++; if (trace_count !== 5'd0 || halted !== 1'b0) begin failures++;
            $display("FAIL drain_held_reset count=%0d halted=%b exp 0 0", trace_count, halted); end
        reset = 1'b1;
        step(200, nop_of(200));
        checks++; if (running !== 1'b1 || trace_count !== 5'd0) begin failures++;
            $display("FAIL drain_idle running=%b count=%0d exp 1 0", running, trace_count); end
        step(200, nop_of(200));
        checks++; if (trace_count !== 5'd1 || cycle_count !== 32'd1) begin failures++;
            $display("FAIL drain_restart count=%0d cycles=%0d exp 1 1", trace_count, cycle_count); end
        step(200, nop_of(200));
        checks++; if (rd_pc !== 32'd200) begin failures++;
            $display("FAIL drain_first_entry pc=%0d exp 200", rd_pc); end
    endtask

    task automatic test_clear();
        restart();
        for (int i = 0; i < 17; i++) step(32'(4 * i), nop_of(32'(4 * i)));
        step(200, HALT); step(204, nop_of(204)); step(208, nop_of(208));
        checks++; if (halted !== 1'b1 || wrapped !== 1'b1) begin failures++;
            $display("FAIL clear_pre halted=%b wrapped=%b exp 1 1", halted, wrapped); end
        clear = 1'b1;
        step(212, nop_of(212));
        clear = 1'b0;
        checks++; if (halted !== 1'b0 || running !== 1'b0 || trace_count !== 5'd0 || wrapped !== 1'b0
                      || cycle_count !== 32'd0 || rd_pc !== 32'd0) begin failures++;
            $display("FAIL clear_halted halted=%b running=%b count=%0d wrapped=%b cycles=%0d rd_pc=%h exp 0 0 0 0 0 0",
                     halted, running, trace_count, wrapped, cycle_count, rd_pc); end
        step(0, nop_of(0));
        step(0, nop_of(0)); step(4, nop_of(4));
        clear = 1'b1;
        step(8, HALT);
        clear = 1'b0;
        checks++; if (halted !== 1'b0 || running !== 1'b0 || trace_count !== 5'd0) begin failures++;
            $display("FAIL clear_halt_word halted=%b running=%b count=%0d exp 0 0 0", halted, running, trace_count); end
        step(12, nop_of(12));
        step(16, nop_of(16));
        checks++; if (running !== 1'b1 || halted !== 1'b0 || trace_count !== 5'd1) begin failures++;
            $display("FAIL clear_no_halt running=%b halted=%b count=%0d exp 1 0 1", running, halted, trace_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_read_port();
        test_wrap();
        test_reset_drain();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
